// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - 2-way BTB write-side controller: update queue, RMW pipeline, invalidate sweep
// Optional feature macro: BTB_BYPASS_EN (forward the write-stage line instead of stalling on an index match).

module btb_split #(
  parameter int DWIDTH = 32,
  parameter int TAGW = 25,
  parameter int CACHEWIDTH = 1 + 2 * (DWIDTH + TAGW + 1)
) (
  input  logic [CACHEWIDTH-1:0] cache_line,
  input  logic [TAGW-1:0]       wa,
  input  logic [DWIDTH-1:0]     din,
  output logic [CACHEWIDTH-1:0] dout
);
  localparam int ENTW = DWIDTH + TAGW + 1;

  logic [ENTW-1:0] e1, e2, new_entry;
  logic            fifo, hit1, hit2, use1;

  // Line layout: {fifo, entry2, entry1}; entry = {target, tag, valid}.
  assign e1        = cache_line[ENTW-1:0];
  assign e2        = cache_line[2*ENTW-1:ENTW];
  assign fifo      = cache_line[CACHEWIDTH-1];
  assign new_entry = {din, wa, 1'b1};
  assign hit1      = e1[0] && (e1[TAGW:1] == wa);
  assign hit2      = e2[0] && (e2[TAGW:1] == wa);
  // A tag hit overwrites in place; otherwise fifo picks the victim. fifo then points at the other way.
  assign use1      = hit1 || (!hit2 && !fifo);
  assign dout      = use1 ? {1'b1, e2, new_entry} : {1'b0, new_entry, e1};
endmodule

module btb_update_ctrl #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int LINES = 128,
  parameter int QDEPTH = 4,
  parameter int INDEXWIDTH = $clog2(LINES),
  parameter int CACHEWIDTH = 1 + 2 * (DWIDTH + AWIDTH - INDEXWIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [AWIDTH-1:0]     upd_addr,
  input  logic [DWIDTH-1:0]     upd_target,
  output logic                  ram_re,
  output logic [INDEXWIDTH-1:0] ram_raddr,
  input  logic [CACHEWIDTH-1:0] ram_rdata,
  output logic                  ram_we,
  output logic [INDEXWIDTH-1:0] ram_waddr,
  output logic [CACHEWIDTH-1:0] ram_wdata,
  output logic                  init_done,
  output logic                  busy
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CNTW = $clog2(QDEPTH + 1);
  localparam int TAGW = AWIDTH - INDEXWIDTH;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state, state_nxt;
  logic [INDEXWIDTH-1:0]   sweep_cnt, sweep_cnt_nxt;

  logic [AWIDTH-1:0]       q_addr [QDEPTH];
  logic [DWIDTH-1:0]       q_target [QDEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CNTW-1:0]         q_count;
  logic                    q_empty, q_full, push, pop, hazard, stall;

  logic                    ws_valid;
  logic [AWIDTH-1:0]       ws_addr;
  logic [DWIDTH-1:0]       ws_target;
  logic [INDEXWIDTH-1:0]   head_idx, ws_idx;
  logic [CACHEWIDTH-1:0]   ws_line, split_line;

  assign head_idx  = q_addr[rd_ptr][INDEXWIDTH-1:0];
  assign ws_idx    = ws_addr[INDEXWIDTH-1:0];
  assign q_empty   = (q_count == '0);
  assign q_full    = (q_count == CNTW'(QDEPTH));
  assign hazard    = ws_valid && (head_idx == ws_idx);
  assign upd_ready = (state == S_RUN) && !q_full && !flush;
  assign push      = upd_valid && upd_ready;
  assign pop       = (state == S_RUN) && !q_empty && !stall && !flush;
  assign init_done = (state == S_RUN);
  assign busy      = ((state == S_INIT) && !rst) || !q_empty || ws_valid;

`ifdef BTB_BYPASS_EN
  logic                  ws_fwd;
  logic [CACHEWIDTH-1:0] last_line;

  assign stall = 1'b0;
  // The array returns the pre-write line on a same-cycle collision, so reuse what was just written.
  assign ws_line = ws_fwd ? last_line : ram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_fwd    <= 1'b0;
      last_line <= '0;
    end else begin
      ws_fwd <= pop && hazard;
      if (ram_we) last_line <= ram_wdata;
    end
  end
`else
  assign stall   = hazard;
  assign ws_line = ram_rdata;
`endif

  btb_split #(
    .DWIDTH(DWIDTH),
    .TAGW(TAGW),
    .CACHEWIDTH(CACHEWIDTH)
  ) split (
    .cache_line(ws_line),
    .wa(ws_addr[AWIDTH-1:INDEXWIDTH]),
    .din(ws_target),
    .dout(split_line)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr]   <= upd_addr;
      q_target[wr_ptr] <= upd_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      q_count <= q_count + CNTW'(push) - CNTW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_valid  <= 1'b0;
      ws_addr   <= '0;
      ws_target <= '0;
    end else begin
      ws_valid <= pop;
      if (pop) begin
        ws_addr   <= q_addr[rd_ptr];
        ws_target <= q_target[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    ram_re        = 1'b0;
    ram_raddr     = '0;
    ram_we        = 1'b0;
    ram_waddr     = '0;
    ram_wdata     = '0;
    if (flush) begin
      state_nxt     = S_INIT;
      sweep_cnt_nxt = '0;
    end else begin
      case (state)
        S_INIT: begin
          ram_we        = !rst;
          ram_waddr     = sweep_cnt;
          sweep_cnt_nxt = sweep_cnt + INDEXWIDTH'(1);
          if (sweep_cnt == INDEXWIDTH'(LINES - 1)) state_nxt = S_RUN;
        end
        S_RUN: begin
          ram_re    = pop;
          ram_raddr = pop ? head_idx : '0;
          ram_we    = ws_valid;
          ram_waddr = ws_valid ? ws_idx : '0;
          ram_wdata = ws_valid ? split_line : '0;
        end
        default: state_nxt = S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - scoreboard bench for btb_update_ctrl with a read-old array model
module tb_btb_update_ctrl;
  localparam int AW = 32, DW = 32, LINES = 128, IW = 7, TW = 25, EW = 58, CW = 117;
  localparam logic [CW-1:0] LINE_SINGLE = {1'b1, 58'd0, 32'h1234, 25'd1, 1'b1};
  localparam logic [CW-1:0] LINE_B2B = {1'b0, 32'hBBBB, 25'd2, 1'b1, 32'hAAAA, 25'd1, 1'b1};
  localparam logic [CW-1:0] LINE_REUPD = {1'b1, 32'hBBBB, 25'd2, 1'b1, 32'h5555, 25'd1, 1'b1};

  logic clk = 1'b0;
  logic rst, flush, upd_valid, upd_ready, ram_re, ram_we, init_done, busy;
  logic [AW-1:0] upd_addr;
  logic [DW-1:0] upd_target;
  logic [IW-1:0] ram_raddr, ram_waddr;
  logic [CW-1:0] ram_rdata, ram_wdata;

  logic [CW-1:0] mem [LINES];
  logic [CW-1:0] model [LINES];

  logic [AW-1:0] pend_a [$];
  logic [DW-1:0] pend_t [$];
  logic [IW-1:0] sb_idx [$];
  logic [CW-1:0] sb_line [$];
  int wr_cyc [$];
  int rd_cyc [$];
  logic [IW-1:0] rd_idx [$];
  int cyc, checks, errors;
  bit saw_not_ready;

  always #5 clk = ~clk;

  btb_update_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_target(upd_target),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .init_done(init_done), .busy(busy)
  );

  // Array model: synchronous read, read-old when read and write hit the same line.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) mem[i] <= '1;
      ram_rdata <= '0;
    end else begin
      if (ram_re) ram_rdata <= mem[ram_raddr];
      if (ram_we) mem[ram_waddr] <= ram_wdata;
    end
  end

  function automatic logic [CW-1:0] model_update(input logic [CW-1:0] line, input logic [AW-1:0] a,
                                                 input logic [DW-1:0] t);
    logic [EW-1:0] way0, way1, fresh;
    logic [TW-1:0] tag;
    logic victim1;
    tag   = a[AW-1:IW];
    way0  = line[EW-1:0];
    way1  = line[2*EW-1:EW];
    fresh = {t, tag, 1'b1};
    if (way0[0] && way0[TW:1] == tag) victim1 = 1'b0;
    else if (way1[0] && way1[TW:1] == tag) victim1 = 1'b1;
    else victim1 = line[CW-1];
    return victim1 ? {1'b0, fresh, way0} : {1'b1, way1, fresh};
  endfunction

  task automatic run_traffic(input int budget);
    int n;
    logic [IW-1:0] ix;
    n = 0;
    wr_cyc.delete(); rd_cyc.delete(); rd_idx.delete();
    saw_not_ready = 0;
    while ((pend_a.size() != 0 || sb_idx.size() != 0) && n < budget) begin
      @(negedge clk);
      cyc++; n++;
      if (ram_re === 1'b1) begin
        rd_cyc.push_back(cyc);
        rd_idx.push_back(ram_raddr);
      end
      if (ram_we === 1'b1) begin
        wr_cyc.push_back(cyc);
        checks++;
        if (sb_idx.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got idx %0d data %h, required no write", ram_waddr, ram_wdata);
        end else begin
          if (ram_waddr !== sb_idx[0] || ram_wdata !== sb_line[0]) begin
            errors++;
            $display("FAIL write_data: got idx %0d data %h, required idx %0d data %h",
                     ram_waddr, ram_wdata, sb_idx[0], sb_line[0]);
          end
          void'(sb_idx.pop_front());
          void'(sb_line.pop_front());
        end
      end
      if (pend_a.size() != 0) begin
        upd_valid = 1'b1; upd_addr = pend_a[0]; upd_target = pend_t[0];
        #1;
        if (upd_ready !== 1'b1) saw_not_ready = 1;
        else begin
          ix = upd_addr[IW-1:0];
          model[ix] = model_update(model[ix], upd_addr, upd_target);
          sb_idx.push_back(ix);
          sb_line.push_back(model[ix]);
          void'(pend_a.pop_front());
          void'(pend_t.pop_front());
        end
      end else upd_valid = 1'b0;
    end
    upd_valid = 1'b0;
    checks++;
    if (pend_a.size() != 0 || sb_idx.size() != 0) begin
      errors++;
      $display("FAIL traffic_timeout: got %0d pending %0d outstanding, required 0 0", pend_a.size(), sb_idx.size());
      pend_a.delete(); pend_t.delete(); sb_idx.delete(); sb_line.delete();
    end
  endtask

  task automatic check_sweep(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < LINES; i++) begin
      if (ram_we !== 1'b1 || ram_waddr !== 7'(i) || ram_wdata !== '0 || ram_re !== 1'b0 || init_done !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_sweep: got %0d bad sweep cycles, required 0", name, bad);
    end
    checks++;
    if (init_done !== 1'b1 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got init_done %b ram_we %b, required 1 0", name, init_done, ram_we);
    end
    for (int i = 0; i < LINES; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; upd_valid = 1'b0; upd_addr = '0; upd_target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || ram_re !== 1'b0) begin
      errors++; $display("FAIL reset_ram: got we %b re %b, required 0 0", ram_we, ram_re);
    end
    checks++;
    if (init_done !== 1'b0 || upd_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got done %b ready %b busy %b, required 0 0 0", init_done, upd_ready, busy);
    end
    rst = 1'b0;
    #1;
    check_sweep("reset");
  endtask

  task automatic test_single();
    pend_a.push_back(32'h85); pend_t.push_back(32'h1234);
    run_traffic(50);
    checks++;
    if (rd_idx.size() != 1 || rd_idx[0] !== 7'd5) begin
      errors++; $display("FAIL single_read: got %0d reads, required one at idx 5", rd_idx.size());
    end
    checks++;
    if (wr_cyc.size() != 1 || rd_cyc.size() != 1 || wr_cyc[0] != rd_cyc[0] + 1) begin
      errors++; $display("FAIL single_latency: got %0d writes, required one write the cycle after the read", wr_cyc.size());
    end
    @(posedge clk); #1;
    checks++;
    if (mem[5] !== LINE_SINGLE) begin
      errors++; $display("FAIL single_line: got %h, required %h", mem[5], LINE_SINGLE);
    end
  endtask

  task automatic test_back_to_back();
    int exp_gap;
`ifdef BTB_BYPASS_EN
    exp_gap = 1;
`else
    exp_gap = 2;
`endif
    pend_a.push_back(32'h85);  pend_t.push_back(32'hAAAA);
    pend_a.push_back(32'h105); pend_t.push_back(32'hBBBB);
    run_traffic(50);
    checks++;
    if (wr_cyc.size() != 2 || wr_cyc[1] - wr_cyc[0] != exp_gap) begin
      errors++; $display("FAIL b2b_gap: got %0d writes gap %0d, required 2 writes gap %0d",
                         wr_cyc.size(), (wr_cyc.size() == 2) ? wr_cyc[1] - wr_cyc[0] : -1, exp_gap);
    end
    @(posedge clk); #1;
    checks++;
    if (mem[5] !== LINE_B2B) begin
      errors++; $display("FAIL b2b_line: got %h, required %h", mem[5], LINE_B2B);
    end
  endtask

  task automatic test_reupdate();
    pend_a.push_back(32'h85); pend_t.push_back(32'h5555);
    run_traffic(50);
    @(posedge clk); #1;
    checks++;
    if (mem[5] !== LINE_REUPD) begin
      errors++; $display("FAIL reupdate_line: got %h, required %h", mem[5], LINE_REUPD);
    end
  endtask

  task automatic test_same_index_stream();
    bit exp_nr;
    int bad_gap;
`ifdef BTB_BYPASS_EN
    exp_nr = 0;
`else
    exp_nr = 1;
`endif
    for (int i = 0; i < 8; i++) begin
      pend_a.push_back({25'((i % 3) + 1), 7'd9});
      pend_t.push_back(32'hC000 + i);
    end
    run_traffic(100);
    checks++;
    if (saw_not_ready != exp_nr) begin
      errors++; $display("FAIL stream_backpressure: got ready-low seen %0d, required %0d", saw_not_ready, exp_nr);
    end
    bad_gap = 0;
    for (int i = 1; i < wr_cyc.size(); i++) if (wr_cyc[i] - wr_cyc[i-1] != 1 + int'(exp_nr)) bad_gap++;
    checks++;
    if (wr_cyc.size() != 8 || bad_gap != 0) begin
      errors++; $display("FAIL stream_rate: got %0d writes %0d bad gaps, required 8 writes 0 bad gaps", wr_cyc.size(), bad_gap);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      pend_a.push_back({25'($urandom_range(1, 3)), 7'($urandom_range(3, 4))});
      pend_t.push_back($urandom);
    end
    run_traffic(200);
  endtask

  task automatic test_flush();
    int bad;
    checks++;
    if (init_done !== 1'b1) begin
      errors++; $display("FAIL flush_pre_done: got %b, required 1", init_done);
    end
    @(negedge clk);
    upd_valid = 1'b1; upd_addr = 32'h85; upd_target = 32'h1111;
    #1;
    checks++;
    if (upd_ready !== 1'b1) begin
      errors++; $display("FAIL flush_pre_ready: got %b, required 1", upd_ready);
    end
    @(negedge clk);
    checks++;
    if (ram_re !== 1'b1 || ram_raddr !== 7'd5) begin
      errors++; $display("FAIL flush_issue: got re %b idx %0d, required 1 5", ram_re, ram_raddr);
    end
    upd_addr = 32'h206; upd_target = 32'h2222;
    @(posedge clk); #1;
    flush = 1'b1; upd_addr = 32'h307; upd_target = 32'h3333;
    #1;
    checks++;
    if (ram_we !== 1'b0 || ram_re !== 1'b0 || upd_ready !== 1'b0) begin
      errors++; $display("FAIL flush_suppress: got we %b re %b ready %b, required 0 0 0", ram_we, ram_re, upd_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; upd_valid = 1'b0;
    checks++;
    if (init_done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL flush_restart: got done %b busy %b, required 0 1", init_done, busy);
    end
    @(negedge clk); #1;
    check_sweep("flush");
    checks++;
    if (busy !== 1'b0 || ram_re !== 1'b0) begin
      errors++; $display("FAIL flush_queue_drop: got busy %b re %b, required 0 0", busy, ram_re);
    end
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < LINES; i++) if (mem[i] !== '0) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL flush_array: got %0d nonzero lines, required 0", bad);
    end
  endtask

  task automatic test_final_array();
    int bad;
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < LINES; i++) if (mem[i] !== model[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL final_array: got %0d lines differing from model, required 0", bad);
    end
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_reupdate();
    test_same_index_stream();
    test_random();
    test_final_array();
    test_flush();
    test_single();
    test_final_array();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
